mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Byte-serial memory controller. Sits directly downstream of the MEM stage and beside instruction fetch.
//  Serves load/store requests of 1..4 bytes over an 8-bit synchronous RAM port.
//  Also serves 4-byte fetches from IF. Reports progress to MEM through mem_status (IDLE/BUSY/DONE).
// PARAMETERS
//  ADDR_WIDTH  32  width of request addresses and mem_a
//  DATA_WIDTH  32  width of request data/result words (4 bytes, fixed)
// PORTS
//  clk             in   1   clock; all state changes on posedge
//  rst             in   1   reset: synchronous, active-high
//  rw_mem          in   3   MEM request: [1:0]=01 read, 10 write, 00/11 none; [2] ignored
//  addr_to_mem     in   32  MEM byte address
//  data_to_mem     in   32  MEM store data; byte i = bits [8i+7:8i]
//  quantity        in   4   bytes to transfer; [2:0] used; legal 1,2,4
//  data_from_mem   out  32  assembled load data, zero-extended
//  mem_status      out  2   00 IDLE, 01 BUSY, 10 DONE (registered)
//  if_req          in   1   IF fetch request (level, held until if_done)
//  if_addr         in   32  IF fetch address
//  if_data         out  32  fetched instruction word
//  if_done         out  1   one-cycle pulse, if_data valid in that cycle
//  mem_din         in   8   RAM read byte; valid the cycle after its address
//  mem_dout        out  8   RAM write byte
//  mem_a           out  32  RAM byte address
//  mem_wr          out  1   1 = write mem_dout to mem_a this cycle
// BEHAVIOUR
//  Reset:
//  - FSM goes to IDLE. mem_status=IDLE.
//  - data_from_mem, if_data, mem_a, mem_dout cleared to 0; if_done=0; mem_wr=0.
//  - A reset mid-transfer aborts it. RAM may hold a partially written store. No DONE or if_done is issued.
//  FSM states: IDLE, DREAD, DWRITE, IREAD, DONE.
//  IDLE: request sampling at each posedge.
//  - Arbitration: a MEM request wins over if_req when both are present. No preemption once a transfer starts.
//  - On accept: latch address, store data, rw and N=quantity[2:0]; clear the byte counter; mem_status <= BUSY.
//  - IF requests use N=4.
//  - N=0: go straight to DONE with data_from_mem=0 and no RAM activity.
//  Reads (DREAD/IREAD):
//  - For i=0..N-1, mem_a=addr+i in consecutive cycles 1..N after acceptance (cycle 0 = accept edge).
//  - Byte i is captured from mem_din one cycle later into bits [8i+7:8i]; unused upper bytes are 0.
//  - After the last byte is captured (end of cycle N+1), the result is written to data_from_mem or if_data.
//  - DONE follows in cycle N+2: mem_status=DONE for data, if_done=1 for IF.
//  Writes (DWRITE):
//  - In cycles 1..N: mem_wr=1, mem_a=addr+i, mem_dout=byte i, little-endian.
//  - mem_status=DONE in cycle N+1. data_from_mem is unchanged.
//  DONE state:
//  - Lasts exactly one cycle, then IDLE.
//  - The next request is sampled no earlier than the edge ending the IDLE cycle. No back-to-back accept from DONE.
//  - MEM drops rw_mem combinationally while DONE is seen. A still-asserted rw_mem in the following IDLE cycle is a new request.
//  Other rules:
//  - mem_status=BUSY in all cycles from acceptance until DONE.
//  - mem_status stays IDLE while an IF transfer is in progress; MEM must keep rw_mem asserted and stall.
//  - Request inputs are ignored outside IDLE, so changes mid-transfer have no effect.
//  - Address arithmetic wraps modulo 2^ADDR_WIDTH.
//  - mem_wr=0 in every state other than DWRITE; mem_a holds its last value when idle.
//  - data_from_mem and if_data hold their values until the next completed read of the same kind.
// TESTING
//  1) RAM[0x100..0x103]=11,22,33,44; rw=01, addr=0x100, qty=4.
//     -> BUSY cycles 1..5, DONE cycle 6, data_from_mem=0x44332211.
//  2) rw=10, addr=0x200, data=0xAABBCCDD, qty=2.
//     -> mem_wr pulses in cycles 1,2 with (0x200,DD),(0x201,CC); DONE cycle 3; RAM[0x202] untouched.
//  3) rw=01, qty=1, RAM=0x80.
//     -> data_from_mem=0x00000080 (zero-extended; sign extension is MEM's job).
//  4) if_req and MEM read both raised in the same cycle.
//     -> MEM is served first; IF starts the cycle after MEM's DONE+IDLE; if_done pulses once with the correct word.
//  5) Reset asserted in cycle 2 of a 4-byte store.
//     -> next cycle mem_wr=0, mem_status=IDLE; no DONE issued.
//  6) addr=0xFFFFFFFF, qty=2 read.
//     -> mem_a sequence 0xFFFFFFFF, 0x00000000 (wrap).

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller between the MEM stage / instruction fetch and an
// 8-bit synchronous RAM.
//
// Serves MEM loads/stores of 0..7 bytes (legal 1, 2, 4) and 4-byte IF fetches, one byte
// per cycle. MEM has priority over IF; a started transfer is never preempted.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rw_mem          MEM request, [1:0]=01 read, 10 write, else none
//   addr_to_mem     MEM byte address
//   data_to_mem     MEM store data, little-endian bytes
//   quantity        byte count, [2:0] used
//   data_from_mem   assembled load data, zero-extended
//   mem_status      00 idle, 01 busy, 10 done (registered)
//   if_req/if_addr  IF fetch request (level) and address
//   if_data/if_done fetched word and its one-cycle valid pulse
//   mem_din         RAM read byte, valid the cycle after its address
//   mem_dout/mem_a/mem_wr  RAM write byte, byte address, write enable
module mem_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            rw_mem,
    input  logic [ADDR_WIDTH-1:0] addr_to_mem,
    input  logic [DATA_WIDTH-1:0] data_to_mem,
    input  logic [3:0]            quantity,
    output logic [DATA_WIDTH-1:0] data_from_mem,
    output logic [1:0]            mem_status,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_data,
    output logic                  if_done,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr
);

    localparam logic [1:0] StatusIdle = 2'b00;
    localparam logic [1:0] StatusBusy = 2'b01;
    localparam logic [1:0] StatusDone = 2'b10;

    typedef enum logic [2:0] {StIdle, StDread, StDwrite, StIread, StDone} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [2:0]            n_q, n_d;
    // Cycle index within the transfer: equals k during cycle k after acceptance.
    logic [3:0]            cyc_q, cyc_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
    logic [7:0]            mem_dout_q, mem_dout_d;
    logic [1:0]            status_q, status_d;
    logic [DATA_WIDTH-1:0] dfm_q, dfm_d;
    logic [DATA_WIDTH-1:0] ifd_q, ifd_d;
    logic                  if_done_q, if_done_d;

    logic                  mem_rd_req, mem_wr_req;
    logic [3:0]            cap_idx;
    logic [DATA_WIDTH-1:0] wdata_shift;
    logic                  unused_bits;

    assign unused_bits = ^{rw_mem[2], quantity[3]};

    assign mem_rd_req = (rw_mem[1:0] == 2'b01);
    assign mem_wr_req = (rw_mem[1:0] == 2'b10);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        n_d         = n_q;
        cyc_d       = cyc_q;
        buf_d       = buf_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        status_d    = status_q;
        dfm_d       = dfm_q;
        ifd_d       = ifd_q;
        if_done_d   = 1'b0;
        cap_idx     = cyc_q - 4'd2;
        wdata_shift = wdata_q >> {cyc_q[1:0], 3'b000};

        unique case (state_q)
            StIdle: begin
                if (mem_rd_req || mem_wr_req) begin
                    addr_d  = addr_to_mem;
                    wdata_d = data_to_mem;
                    n_d     = quantity[2:0];
                    cyc_d   = 4'd1;
                    buf_d   = '0;
                    if (quantity[2:0] == 3'd0) begin
                        // Empty transfer: complete without touching the RAM.
                        state_d  = StDone;
                        status_d = StatusDone;
                        dfm_d    = '0;
                    end else begin
                        state_d    = mem_rd_req ? StDread : StDwrite;
                        status_d   = StatusBusy;
                        mem_a_d    = addr_to_mem;
                        mem_dout_d = data_to_mem[7:0];
                    end
                end else if (if_req) begin
                    addr_d  = if_addr;
                    n_d     = 3'd4;
                    cyc_d   = 4'd1;
                    buf_d   = '0;
                    state_d = StIread;
                    mem_a_d = if_addr;
                end
            end
            StDread, StIread: begin
                cyc_d = cyc_q + 4'd1;
                if (cyc_q < {1'b0, n_q}) begin
                    mem_a_d = addr_q + ADDR_WIDTH'(cyc_q);
                end
                // RAM returns a byte one cycle after its address, so byte i arrives in cycle i+2.
                if (cyc_q >= 4'd2 && cap_idx < 4'd4) begin
                    buf_d[{cap_idx[1:0], 3'b000} +: 8] = mem_din;
                end
                if (cyc_q == {1'b0, n_q} + 4'd1) begin
                    state_d = StDone;
                    if (state_q == StDread) begin
                        dfm_d    = buf_d;
                        status_d = StatusDone;
                    end else begin
                        ifd_d     = buf_d;
                        if_done_d = 1'b1;
                    end
                end
            end
            StDwrite: begin
                cyc_d = cyc_q + 4'd1;
                if (cyc_q < {1'b0, n_q}) begin
                    mem_a_d    = addr_q + ADDR_WIDTH'(cyc_q);
                    mem_dout_d = (cyc_q < 4'd4) ? wdata_shift[7:0] : 8'h00;
                end
                if (cyc_q == {1'b0, n_q}) begin
                    state_d  = StDone;
                    status_d = StatusDone;
                end
            end
            StDone: begin
                state_d  = StIdle;
                status_d = StatusIdle;
            end
            default: begin
                state_d  = StIdle;
                status_d = StatusIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wdata_q    <= '0;
            n_q        <= '0;
            cyc_q      <= '0;
            buf_q      <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            status_q   <= StatusIdle;
            dfm_q      <= '0;
            ifd_q      <= '0;
            if_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            n_q        <= n_d;
            cyc_q      <= cyc_d;
            buf_q      <= buf_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            status_q   <= status_d;
            dfm_q      <= dfm_d;
            ifd_q      <= ifd_d;
            if_done_q  <= if_done_d;
        end
    end

    // Write enable follows the state directly so it covers exactly cycles 1..N of a store.
    assign mem_wr        = (state_q == StDwrite);
    assign mem_a         = mem_a_q;
    assign mem_dout      = mem_dout_q;
    assign mem_status    = status_q;
    assign data_from_mem = dfm_q;
    assign if_data       = ifd_q;
    assign if_done       = if_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized traffic, checked
// against a byte-array memory model and the cycle timing rules of the controller.
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic [2:0]  rw_mem;
    logic [31:0] addr_to_mem;
    logic [31:0] data_to_mem;
    logic [3:0]  quantity;
    logic [31:0] data_from_mem;
    logic [1:0]  mem_status;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_done;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    // RAM (aliased to 1 KiB) with a bench-side load port used only during reset.
    logic [7:0]  ram [0:1023];
    logic [7:0]  model_mem [0:1023];
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [7:0]  ld_data;

    int          n_checks;
    int          n_pass;
    logic [31:0] last_dfm;
    logic [31:0] last_ifd;

    mem_ctrl #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rw_mem       (rw_mem),
        .addr_to_mem  (addr_to_mem),
        .data_to_mem  (data_to_mem),
        .quantity     (quantity),
        .data_from_mem(data_from_mem),
        .mem_status   (mem_status),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_data      (if_data),
        .if_done      (if_done),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout),
        .mem_a        (mem_a),
        .mem_wr       (mem_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_en) ram[ld_addr] <= ld_data;
        else if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
        mem_din <= ram[mem_a[9:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic load(input int addr, input logic [7:0] val);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = 10'(addr);
        ld_data = val;
        model_mem[addr] = val;
    endtask

    // One MEM transfer from request to the IDLE cycle after DONE.
    task automatic mem_op(input logic [1:0] rw, input logic [31:0] addr, input logic [31:0] wdata,
                          input int n, input bit raise_if, input logic [31:0] if_a);
        logic [31:0] exp;
        logic [31:0] a;
        int          last;
        bit          is_rd;
        is_rd = (rw == 2'b01);
        @(negedge clk);
        rw_mem      = {1'($urandom_range(0, 1)), rw};
        addr_to_mem = addr;
        data_to_mem = wdata;
        quantity    = {1'($urandom_range(0, 1)), 3'(n)};
        if (raise_if) begin
            if_req  = 1'b1;
            if_addr = if_a;
        end
        exp = 32'h0;
        for (int i = 0; i < n && i < 4; i++) begin
            a = addr + 32'(i);
            exp[8*i +: 8] = model_mem[a[9:0]];
        end
        last = (n == 0) ? 0 : (is_rd ? n + 1 : n);
        @(posedge clk);
        #1;
        // Everything except the direction may change once the transfer is running.
        addr_to_mem = $urandom;
        data_to_mem = $urandom;
        quantity    = 4'($urandom);
        rw_mem[2]   = 1'($urandom);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            check("busy", 32'(mem_status), 32'd1);
            a = addr + 32'(c - 1);
            if (!is_rd) begin
                check("wr_en", 32'(mem_wr), 32'd1);
                check("wr_addr", mem_a, a);
                check("wr_byte", 32'(mem_dout), 32'(wdata[8*(c-1) +: 8]));
            end else begin
                check("rd_no_wr", 32'(mem_wr), 32'd0);
                if (c <= n) check("rd_addr", mem_a, a);
            end
        end
        @(negedge clk);
        check("done", 32'(mem_status), 32'd2);
        check("done_no_wr", 32'(mem_wr), 32'd0);
        check("done_no_ifdone", 32'(if_done), 32'd0);
        check("ifd_hold", if_data, last_ifd);
        if (is_rd) begin
            check("rd_data", data_from_mem, exp);
            last_dfm = exp;
        end else begin
            check("dfm_hold", data_from_mem, last_dfm);
        end
        rw_mem = 3'b000;
        if (!is_rd) begin
            for (int i = 0; i < n; i++) begin
                a = addr + 32'(i);
                model_mem[a[9:0]] = wdata[8*i +: 8];
            end
            for (int i = 0; i <= n; i++) begin
                a = addr + 32'(i);
                check("ram_after_wr", 32'(ram[a[9:0]]), 32'(model_mem[a[9:0]]));
            end
        end
        @(negedge clk);
        check("idle", 32'(mem_status), 32'd0);
        check("idle_no_wr", 32'(mem_wr), 32'd0);
    endtask

    // One IF fetch; if raised is set the request is already pending and accepted at the next edge.
    task automatic if_op(input logic [31:0] addr, input bit raised);
        logic [31:0] exp;
        logic [31:0] a;
        if (!raised) begin
            @(negedge clk);
            if_req  = 1'b1;
            if_addr = addr;
        end
        for (int i = 0; i < 4; i++) begin
            a = addr + 32'(i);
            exp[8*i +: 8] = model_mem[a[9:0]];
        end
        @(posedge clk);
        #1;
        if_addr = $urandom;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check("if_status_idle", 32'(mem_status), 32'd0);
            check("if_not_done", 32'(if_done), 32'd0);
            check("if_no_wr", 32'(mem_wr), 32'd0);
            a = addr + 32'(c - 1);
            if (c <= 4) check("if_addr", mem_a, a);
        end
        @(negedge clk);
        check("if_done", 32'(if_done), 32'd1);
        check("if_data", if_data, exp);
        check("if_status_idle", 32'(mem_status), 32'd0);
        check("if_dfm_hold", data_from_mem, last_dfm);
        last_ifd = exp;
        if_req   = 1'b0;
        @(negedge clk);
        check("if_done_once", 32'(if_done), 32'd0);
    endtask

    initial begin
        int          qtab [3];
        logic [1:0]  rw;
        int          n;
        logic [31:0] a;
        qtab        = '{1, 2, 4};
        n_checks    = 0;
        n_pass      = 0;
        last_dfm    = 32'h0;
        last_ifd    = 32'h0;
        rst         = 1'b1;
        rw_mem      = 3'b000;
        addr_to_mem = 32'h0;
        data_to_mem = 32'h0;
        quantity    = 4'h0;
        if_req      = 1'b0;
        if_addr     = 32'h0;
        ld_en       = 1'b0;
        ld_addr     = 10'h0;
        ld_data     = 8'h0;

        for (int i = 0; i < 1024; i++) load(i, 8'($urandom));
        load(32'h100, 8'h11);
        load(32'h101, 8'h22);
        load(32'h102, 8'h33);
        load(32'h103, 8'h44);
        load(32'h300, 8'h80);
        @(negedge clk);
        ld_en = 1'b0;

        // Reset state
        check("rst_status", 32'(mem_status), 32'd0);
        check("rst_wr", 32'(mem_wr), 32'd0);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_dout", 32'(mem_dout), 32'd0);
        check("rst_dfm", data_from_mem, 32'h0);
        check("rst_ifd", if_data, 32'h0);
        check("rst_ifdone", 32'(if_done), 32'd0);
        rst = 1'b0;

        // Directed scenarios
        mem_op(2'b01, 32'h100, 32'h0, 4, 1'b0, 32'h0);
        check("t1_word", data_from_mem, 32'h44332211);
        mem_op(2'b10, 32'h200, 32'hAABBCCDD, 2, 1'b0, 32'h0);
        mem_op(2'b01, 32'h300, 32'h0, 1, 1'b0, 32'h0);
        check("t3_zext", data_from_mem, 32'h00000080);
        mem_op(2'b01, 32'h100, 32'h0, 4, 1'b1, 32'h180);
        if_op(32'h180, 1'b1);

        // Reset during cycle 2 of a 4-byte store
        @(negedge clk);
        rw_mem      = 3'b010;
        addr_to_mem = 32'h240;
        data_to_mem = 32'h5A6B7C8D;
        quantity    = 4'd4;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_wr1", 32'(mem_wr), 32'd1);
        @(negedge clk);
        check("rst_mid_wr2", 32'(mem_wr), 32'd1);
        check("rst_mid_a2", mem_a, 32'h241);
        rst    = 1'b1;
        rw_mem = 3'b000;
        @(negedge clk);
        check("rst_abort_wr", 32'(mem_wr), 32'd0);
        check("rst_abort_status", 32'(mem_status), 32'd0);
        check("rst_abort_mem_a", mem_a, 32'h0);
        check("rst_abort_dfm", data_from_mem, 32'h0);
        rst      = 1'b0;
        last_dfm = 32'h0;
        last_ifd = 32'h0;
        model_mem[10'h240] = 8'h8D;
        model_mem[10'h241] = 8'h7C;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_no_done", 32'(mem_status), 32'd0);
            check("rst_no_ifdone", 32'(if_done), 32'd0);
        end
        for (int i = 0; i < 4; i++) check("rst_partial_ram", 32'(ram[10'h240 + 10'(i)]),
                                          32'(model_mem[10'h240 + 10'(i)]));

        // Address wrap
        mem_op(2'b01, 32'hFFFFFFFF, 32'h0, 2, 1'b0, 32'h0);

        // rw_mem codes 00/11 are not requests
        @(negedge clk);
        rw_mem = 3'b011;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("none_status", 32'(mem_status), 32'd0);
            check("none_wr", 32'(mem_wr), 32'd0);
            rw_mem = 3'b111;
        end
        rw_mem = 3'b000;

        // Randomized traffic
        for (int k = 0; k < 30; k++) begin
            int r;
            r = $urandom_range(0, 9);
            a = $urandom;
            if (r < 2) begin
                if_op(a, 1'b0);
            end else begin
                rw = (r < 6) ? 2'b01 : 2'b10;
                n  = qtab[$urandom_range(0, 2)];
                if (rw == 2'b01 && $urandom_range(0, 7) == 0) n = 0;
                mem_op(rw, a, $urandom, n, 1'b0, 32'h0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
